// File: rtl/serial_sub_bs_if.sv
//------------------------------------------------------------------------------
// serial_sub_bs_if : operand/result handshake bundle for serial_sub_bs
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_sub_bs_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] sub_a;
  logic [BIT_WIDTH-1:0] sub_b;
  logic                 b_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] diff;
  logic                 b_out;
  logic                 ovf;

  modport slave (
    input  in_valid, sub_a, sub_b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, ovf
  );

  modport master (
    output in_valid, sub_a, sub_b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_sub_bs.sv
//------------------------------------------------------------------------------
// serial_sub_bs : bit-serial ripple-borrow subtractor, LSB first, valid/ready
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_sub_bs #(
  parameter int BIT_WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  serial_sub_bs_if.slave bus
);

  localparam int CNT_W = $clog2(BIT_WIDTH);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIT_WIDTH - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [BIT_WIDTH-1:0] r_a;
  logic [BIT_WIDTH-1:0] r_b;
  logic                 r_br;
  logic                 r_a_sgn;
  logic                 r_b_sgn;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_WIDTH-1:0] r_diff;
  logic                 r_b_out;
  logic                 r_ovf;

  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_load;
  logic                 w_shift_en;
  logic                 w_last;
  logic                 w_d;
  logic                 w_br_nxt;

  // One full-subtractor cell, reused every cycle on the current LSBs
  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:  if (bus.in_valid)  w_state_nxt = C_RUN;
      C_RUN:   if (w_last)        w_state_nxt = C_DONE;
      C_DONE:  if (bus.out_ready) w_state_nxt = C_IDLE;
      default:                    w_state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == C_IDLE);
    w_out_valid = (r_state == C_DONE);
    w_shift_en  = (r_state == C_RUN);
    w_load      = w_in_ready & bus.in_valid;
    w_last      = w_shift_en & (r_cnt == C_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_a_sgn <= 1'b0;
      r_b_sgn <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_b_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.sub_a;
      r_b     <= bus.sub_b;
      r_br    <= bus.b_in;
      r_a_sgn <= bus.sub_a[BIT_WIDTH-1];
      r_b_sgn <= bus.sub_b[BIT_WIDTH-1];
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_a    <= {1'b0, r_a[BIT_WIDTH-1:1]};
      r_b    <= {1'b0, r_b[BIT_WIDTH-1:1]};
      r_br   <= w_br_nxt;
      r_diff <= {w_d, r_diff[BIT_WIDTH-1:1]};
      r_cnt  <= r_cnt + 1'b1;
      // Final bit: w_d is the result MSB, so flags are resolved on the same edge
      if (w_last) begin
        r_b_out <= w_br_nxt;
        r_ovf   <= (r_a_sgn != r_b_sgn) & (w_d != r_a_sgn);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.diff      = r_diff;
  assign bus.b_out     = r_b_out;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_bs.sv
//------------------------------------------------------------------------------
// tb_serial_sub_bs : directed scoreboard bench for serial_sub_bs (BIT_WIDTH=16)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub_bs;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  serial_sub_bs_if #(.BIT_WIDTH(W)) bus ();

  serial_sub_bs #(.BIT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] r;
    exp_t m;
    r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    m.d  = r[W-1:0];
    m.bo = r[W];
    m.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return m;
  endfunction

  // Drives one op at a negedge; hold > 0 keeps out_ready low that many cycles in DONE
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input int hold);
    exp_t e;
    int   cyc;
    logic seen;
    check({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.sub_a    = a;
    bus.sub_b    = b;
    bus.b_in     = bin;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, bin));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sub_a    = W'($urandom);
    bus.sub_b    = W'($urandom);
    bus.b_in     = 1'($urandom);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_out_valid_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, W);
    e = sb.pop_front();
    check({tag, "_diff"}, bus.diff, e.d);
    check({tag, "_b_out"}, bus.b_out, e.bo);
    check({tag, "_ovf"}, bus.ovf, e.ov);
    check({tag, "_in_ready_done"}, bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.sub_a    = W'($urandom);
      bus.sub_b    = W'($urandom);
      @(negedge clk);
      check({tag, "_hold_out_valid"}, bus.out_valid, 1);
      check({tag, "_hold_diff"}, bus.diff, e.d);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_out_valid"}, bus.out_valid, 0);
    check({tag, "_post_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    int stray;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sub_a     = '0;
    bus.sub_b     = '0;
    bus.b_in      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_b_out", bus.b_out, 0);
    check("rst_ovf", bus.ovf, 0);

    do_op("t1_15m12", 16'd15, 16'd12, 1'b0, 0);
    do_op("t2_12m15", 16'd12, 16'd15, 1'b0, 0);
    do_op("t2_12m15b", 16'd12, 16'd15, 1'b1, 0);
    do_op("t3_0m0b", 16'd0, 16'd0, 1'b1, 0);
    do_op("t3_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_op("t4_8000m1", 16'h8000, 16'h0001, 1'b0, 0);
    do_op("t4_7fff", 16'h7FFF, 16'hFFFF, 1'b0, 0);
    do_op("t5_bp", 16'h1234, 16'h0F0F, 1'b1, 10);

    // Reset in the middle of RUN: result must never appear
    bus.sub_a    = 16'd1234;
    bus.sub_b    = 16'd77;
    bus.b_in     = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_diff", bus.diff, 0);
    check("t6_b_out", bus.b_out, 0);
    check("t6_ovf", bus.ovf, 0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("t6_no_stray_result", stray, 0);
    do_op("t6_100m1", 16'd100, 16'd1, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
